// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: request/result bundle between the cpu55 pipeline and
// the HI/LO multiply/divide unit. The master side is the CPU, the slave side
// is the unit itself.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, cancel,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, cancel,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU engine with built-in HI/LO
// registers (MIPS semantics: HI = high product / remainder, LO = low product /
// quotient). Operands are reduced to magnitudes when latched, the unsigned
// core iterates one bit per cycle, and the FIX state applies the sign.
// Optional build macro HILO_FAST_MULT_EN: multiplies use a one-shot
// combinational multiplier instead of the iterative shift-add loop.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic              clk,
  input logic              rst,
  hilo_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] aMag_q, bMag_q, rsRaw_q;
  logic [WIDTH-1:0] hiAcc_q, loAcc_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             negRes_q, negRem_q, isDiv_q;
  logic             done_q, divZero_q;
`ifdef HILO_FAST_MULT_EN
  logic             fastPend_q;
`endif

  // Request decode; a cancel in the same cycle swallows the request.
  logic             accept, isMulOp, isDivOp, isMthi, isMtlo;
  logic             signedOp, rsNeg, rtNeg;
  logic [WIDTH-1:0] rsMag, rtMag;
  logic             lastIter;

  assign accept   = bus.start && !bus.cancel && (state_q == IDLE);
  assign isMulOp  = (bus.op[2:1] == 2'b00);
  assign isDivOp  = (bus.op[2:1] == 2'b01);
  assign isMthi   = (bus.op == 3'b100);
  assign isMtlo   = (bus.op == 3'b101);
  assign signedOp = !bus.op[0];
  assign rsNeg    = signedOp && bus.rs_val[WIDTH-1];
  assign rtNeg    = signedOp && bus.rt_val[WIDTH-1];
  assign rsMag    = rsNeg ? (-bus.rs_val) : bus.rs_val;
  assign rtMag    = rtNeg ? (-bus.rt_val) : bus.rt_val;
  assign lastIter = (cnt_q == CNT_W'(WIDTH - 1));

  // One shift-add step: conditionally add the multiplicand into the upper
  // half, then shift the whole {hiAcc, loAcc} pair right by one.
  logic [WIDTH:0] mulSum;
  assign mulSum = {1'b0, hiAcc_q} + (loAcc_q[0] ? {1'b0, aMag_q} : '0);

  // One restoring-divide step: bring in the next dividend bit and subtract
  // the divisor if it fits. The true difference is below 2^WIDTH, so the
  // narrow subtraction is exact whenever it is used.
  logic [WIDTH:0]   divShift;
  logic             divFits;
  logic [WIDTH-1:0] divDiff;
  assign divShift = {hiAcc_q, loAcc_q[WIDTH-1]};
  assign divFits  = (divShift >= {1'b0, bMag_q});
  assign divDiff  = divShift[WIDTH-1:0] - bMag_q;

  // Final HI/LO values and div_zero outcome computed in the FIX cycle.
  logic [WIDTH-1:0]   fixHi, fixLo;
  logic               fixDz;
  logic [2*WIDTH-1:0] prodNeg;
  always_comb begin
    fixHi   = hiAcc_q;
    fixLo   = loAcc_q;
    fixDz   = divZero_q;
    prodNeg = -{hiAcc_q, loAcc_q};
    if (isDiv_q) begin
      if (bMag_q == '0) begin
        fixHi = rsRaw_q;
        fixLo = '1;
        fixDz = 1'b1;
      end else begin
        fixLo = negRes_q ? (-loAcc_q) : loAcc_q;
        fixHi = negRem_q ? (-hiAcc_q) : hiAcc_q;
      end
    end else if (negRes_q) begin
      {fixHi, fixLo} = prodNeg;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; cancel returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    if (bus.cancel) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && isMulOp) begin
`ifdef HILO_FAST_MULT_EN
            state_d = FIX;
`else
            state_d = MUL;
`endif
          end else if (accept && isDivOp) begin
            state_d = DIV;
          end
        end
        MUL:     if (lastIter) state_d = FIX;
        DIV:     if (lastIter) state_d = FIX;
        FIX: begin
`ifdef HILO_FAST_MULT_EN
          if (!fastPend_q) state_d = IDLE;
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: busy follows the state, the rest are registered.
  always_comb begin
    bus.busy     = (state_q != IDLE);
    bus.done     = done_q;
    bus.div_zero = divZero_q;
    bus.hi       = hi_q;
    bus.lo       = lo_q;
  end

  // Datapath: operand latch, iteration, and HI/LO write-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      aMag_q     <= '0;
      bMag_q     <= '0;
      rsRaw_q    <= '0;
      hiAcc_q    <= '0;
      loAcc_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      negRes_q   <= 1'b0;
      negRem_q   <= 1'b0;
      isDiv_q    <= 1'b0;
      done_q     <= 1'b0;
      divZero_q  <= 1'b0;
`ifdef HILO_FAST_MULT_EN
      fastPend_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (isMthi) hi_q <= bus.rs_val;
            if (isMtlo) lo_q <= bus.rs_val;
            if (isMulOp || isDivOp) begin
              aMag_q   <= rsMag;
              bMag_q   <= rtMag;
              rsRaw_q  <= bus.rs_val;
              negRes_q <= rsNeg ^ rtNeg;
              negRem_q <= rsNeg;
              isDiv_q  <= isDivOp;
              cnt_q    <= '0;
              hiAcc_q  <= '0;
              loAcc_q  <= isDivOp ? rsMag : rtMag;
`ifdef HILO_FAST_MULT_EN
              fastPend_q <= isMulOp;
`endif
            end
            if (isDivOp) divZero_q <= 1'b0;
          end
        end
        MUL: begin
          hiAcc_q <= mulSum[WIDTH:1];
          loAcc_q <= {mulSum[0], loAcc_q[WIDTH-1:1]};
          cnt_q   <= cnt_q + 1'b1;
        end
        DIV: begin
          hiAcc_q <= divFits ? divDiff : divShift[WIDTH-1:0];
          loAcc_q <= {loAcc_q[WIDTH-2:0], divFits};
          cnt_q   <= cnt_q + 1'b1;
        end
        FIX: begin
`ifdef HILO_FAST_MULT_EN
          if (fastPend_q) begin
            {hiAcc_q, loAcc_q} <= (2*WIDTH)'(aMag_q) * (2*WIDTH)'(bMag_q);
            fastPend_q         <= 1'b0;
          end else
`endif
          if (!bus.cancel) begin
            hi_q      <= fixHi;
            lo_q      <= fixLo;
            divZero_q <= fixDz;
            done_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: scoreboard bench. Stimulus computes MIPS HI/LO results
// with plain 64-bit arithmetic and queues them; a monitor pops and compares
// whenever done pulses, including the completion latency.
module tb_hilo_muldiv_unit;
  localparam int W = 32;
`ifdef HILO_FAST_MULT_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hilo_muldiv_unit_if #(.WIDTH(W)) bus ();

  hilo_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
    string       name;
  } exp_t;

  exp_t        expQ[$];
  exp_t        monE;
  int          checks = 0;
  int          fails = 0;
  int          cycle = 0;
  logic [31:0] modelHi = '0;
  logic [31:0] modelLo = '0;
  logic        modelDz = 1'b0;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference behaviour from the MIPS rules, independent of how the unit iterates.
  function automatic void refModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l,
                                   output logic dz, output bit arith);
    longint      sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = modelHi; l = modelLo; dz = modelDz; arith = 1'b0;
    case (o)
      3'd0: begin arith = 1'b1; p = sa * sb; {h, l} = p; end
      3'd1: begin arith = 1'b1; up = {32'b0, a} * {32'b0, b}; {h, l} = up; end
      3'd2, 3'd3: begin
        arith = 1'b1;
        dz = 1'b0;
        if (b == 32'd0) begin
          l = 32'hFFFF_FFFF; h = a; dz = 1'b1;
        end else if (o == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000; h = 32'd0;
        end else if (o == 3'd2) begin
          l = 32'(sa / sb); h = 32'(sa % sb);
        end else begin
          l = a / b; h = a % b;
        end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endfunction

  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               input bit expectDone, input string name);
    int          n;
    logic [31:0] h, l;
    logic        dz;
    bit          arith;
    exp_t        e;
    @(negedge clk);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; fails++;
      $display("[TB] FAIL %s idle wait: busy still %b after %0d cycles, required 0", name, bus.busy, n);
    end
    refModel(o, a, b, h, l, dz, arith);
    if (o[2:1] == 2'b01) modelDz = 1'b0;
    if (arith && expectDone) begin
      e.hi = h; e.lo = l; e.dz = dz; e.name = name;
      e.due = cycle + 1 + ((o[2:1] == 2'b01) ? DIV_LAT : MUL_LAT);
      expQ.push_back(e);
      modelHi = h; modelLo = l; modelDz = dz;
    end else if (!arith) begin
      modelHi = h; modelLo = l;
    end
    bus.op = o; bus.rs_val = a; bus.rt_val = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (!arith) begin
      checkOutput({name, " hi"}, bus.hi, modelHi);
      checkOutput({name, " lo"}, bus.lo, modelLo);
      checkOutput({name, " busy"}, bus.busy, 0);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL unexpected done: got done=1 at cycle %0d, required no result", cycle);
        end else begin
          monE = expQ.pop_front();
          checkOutput({monE.name, " hi"}, bus.hi, monE.hi);
          checkOutput({monE.name, " lo"}, bus.lo, monE.lo);
          checkOutput({monE.name, " div_zero"}, bus.div_zero, monE.dz);
          checkOutput({monE.name, " latency"}, cycle, monE.due);
          checkOutput({monE.name, " busy at done"}, bus.busy, 0);
        end
      end
    end
  end

  initial begin
    int          n;
    logic [31:0] prevHi, prevLo, ra, rb;
    logic [2:0]  ro;
    bus.start = 1'b0; bus.op = '0; bus.rs_val = '0; bus.rt_val = '0; bus.cancel = 1'b0;

    #3 rst = 1'b0;
    #4;
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset done", bus.done, 0);
    checkOutput("reset div_zero", bus.div_zero, 0);
    checkOutput("reset hi", bus.hi, 0);
    checkOutput("reset lo", bus.lo, 0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, "mult -3*5");
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mult busy length", n, MUL_LAT);

    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "multu max*max");
    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, "div -7/2");
    applyStimulus(3'd3, 32'h0000_0064, 32'h0000_0007, 1'b1, "divu 100/7");
    applyStimulus(3'd3, 32'h0000_0005, 32'h0000_0000, 1'b1, "divu 5/0");
    applyStimulus(3'd2, 32'h0000_0006, 32'h0000_0003, 1'b1, "div 6/3");
    applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div min/-1");
    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 1'b1, "div -7/0");
    applyStimulus(3'd4, 32'h1234_5678, 32'h0, 1'b1, "mthi");
    applyStimulus(3'd5, 32'h9ABC_DEF0, 32'h0, 1'b1, "mtlo");

    // Cancel mid-divide: no result, HI/LO kept, div_zero cleared by the start.
    applyStimulus(3'd2, 32'h0000_0100, 32'h0000_0007, 1'b0, "div cancel");
    repeat (8) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    checkOutput("cancel busy", bus.busy, 0);
    checkOutput("cancel hi", bus.hi, modelHi);
    checkOutput("cancel lo", bus.lo, modelLo);
    checkOutput("cancel div_zero", bus.div_zero, modelDz);
    repeat (40) @(negedge clk);
    checkOutput("cancel quiet hi", bus.hi, 32'h1234_5678);

    // Cancel together with an MTHI request drops the request.
    bus.op = 3'd4; bus.rs_val = 32'hCAFE_0001; bus.start = 1'b1; bus.cancel = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    checkOutput("cancel+mthi hi", bus.hi, modelHi);

    // Requests while busy are ignored.
    prevHi = modelHi;
    prevLo = modelLo;
    applyStimulus(3'd0, 32'h0000_0007, 32'hFFFF_FFF7, 1'b1, "mult ignoring starts");
    @(negedge clk);
    bus.op = 3'd4; bus.rs_val = 32'hDEAD_BEEF; bus.start = 1'b1;
    @(negedge clk);
    bus.op = 3'd3; bus.rs_val = 32'd9; bus.rt_val = 32'd2;
    @(negedge clk);
    bus.op = 3'd5; bus.rs_val = 32'hBEEF_DEAD;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("busy mthi hi", bus.hi, prevHi);
    checkOutput("busy mtlo lo", bus.lo, prevLo);

    // Asynchronous reset in the middle of a multiply.
    applyStimulus(3'd0, 32'h0001_2345, 32'h0000_6789, 1'b1, "mult reset");
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("midop reset busy", bus.busy, 0);
    checkOutput("midop reset done", bus.done, 0);
    checkOutput("midop reset hi", bus.hi, 0);
    checkOutput("midop reset lo", bus.lo, 0);
    checkOutput("midop reset div_zero", bus.div_zero, 0);
    expQ.delete();
    modelHi = '0; modelLo = '0; modelDz = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      applyStimulus(ro, ra, rb, 1'b1, "random");
    end

    n = 0;
    while (expQ.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() > 0) begin
      checks++; fails++;
      $display("[TB] FAIL drain: %0d results outstanding, required 0", expQ.size());
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
